// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// SERIAL_TX_PARITY_EN adds the even-parity state to the frame.
package serial_pkg;

    localparam int DATA_BITS       = 8;
    localparam int CLK_DIV_DEFAULT = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period counter: one-cycle tick on the last cycle of each bit.
// Held at zero while idle and cleared whenever a frame starts.
module serial_baud_gen
    import serial_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = run && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (restart || !run || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Byte-wide serial transmitter with a one-deep holding register.
// SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] ParallelIn,
    input  logic                 nWE,
    output logic                 dataOut,
    output logic                 txBusy,
    output logic                 Empty
);

    tx_state_e state_q;
    tx_state_e state_d;

    logic [DATA_BITS-1:0] hold_q;
    logic [DATA_BITS-1:0] hold_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [2:0]           bit_cnt_q;
    logic [2:0]           bit_cnt_d;
    logic                 empty_q;
    logic                 empty_d;
    logic                 pend_q;
    logic                 pend_d;
    logic                 load;
    logic                 restart;
    logic                 tick;

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;
    logic parity_d;
`endif

    serial_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk     (clk),
        .rst_n   (reset),
        .run     (state_q != S_IDLE),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        empty_d   = empty_q;
        pend_d    = !empty_q;
        load      = 1'b0;
        restart   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (!nWE && empty_q) begin
            hold_d  = ParallelIn;
            empty_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                // pend_q delays the start one cycle after the capture
                if (pend_q && !empty_q) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (!empty_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            state_d   = S_START;
            shift_d   = hold_q;
            bit_cnt_d = 3'd0;
            empty_d   = 1'b1;
            restart   = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_d  = even_parity(hold_q);
`endif
        end
    end

    always_comb begin
        dataOut = STOP_BIT;
        unique case (state_q)
            S_START:  dataOut = START_BIT;
            S_DATA:   dataOut = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: dataOut = parity_q;
`endif
            default:  dataOut = STOP_BIT;
        endcase
    end

    assign txBusy = (state_q != S_IDLE);
    assign Empty  = empty_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            empty_q   <= 1'b1;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            empty_q   <= empty_d;
            pend_q    <= pend_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx at CLK_DIV=4.
// Frame length follows SERIAL_TX_PARITY_EN.
module tb_serial_tx;

    localparam int CLK_DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FCYC = NBITS * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ParallelIn;
    logic       nWE;
    logic       dataOut;
    logic       txBusy;
    logic       Empty;

    int   checks   = 0;
    int   failures = 0;
    logic samp [0:255];
    int   busy_cnt;

    serial_tx #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ParallelIn (ParallelIn),
        .nWE        (nWE),
        .dataOut    (dataOut),
        .txBusy     (txBusy),
        .Empty      (Empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Called on the negedge holding the first sample; ends on the last one.
    task automatic collect(input int n);
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            samp[i] = dataOut;
            if (txBusy) busy_cnt++;
            if (i < n - 1) @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b,
                               input int base);
        logic [3:0] obs;
        for (int k = 0; k < NBITS; k++) begin
            for (int j = 0; j < CLK_DIV; j++) begin
                obs[3-j] = samp[base + k*CLK_DIV + j];
            end
            chk($sformatf("%s_bit%0d", tag, k), {28'd0, obs},
                {28'd0, {4{exp_bit(b, k)}}});
        end
    endtask

    // Returns on the negedge after write edge + 2 (first start-bit sample).
    task automatic write_start(input string tag, input logic [7:0] b);
        @(negedge clk);
        ParallelIn = b;
        nWE        = 1'b0;
        @(negedge clk);
        nWE = 1'b1;
        chk({tag, "_empty0"}, {31'd0, Empty}, 32'd0);
        chk({tag, "_dout_n0"}, {31'd0, dataOut}, 32'd1);
        @(negedge clk);
        chk({tag, "_dout_n1"}, {31'd0, dataOut}, 32'd1);
        chk({tag, "_busy_n1"}, {31'd0, txBusy}, 32'd0);
        @(negedge clk);
        chk({tag, "_dout_n2"}, {31'd0, dataOut}, 32'd0);
        chk({tag, "_empty_n2"}, {31'd0, Empty}, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, txBusy}, 32'd0);
        chk({tag, "_idle_dout"}, {31'd0, dataOut}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int zeros;
        reset      = 1'b0;
        nWE        = 1'b1;
        ParallelIn = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_dout", {31'd0, dataOut}, 32'd1);
        chk("rst_busy", {31'd0, txBusy}, 32'd0);
        chk("rst_empty", {31'd0, Empty}, 32'd1);

        ParallelIn = 8'h5A;
        nWE        = 1'b0;
        @(negedge clk);
        nWE   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ignores_we", {31'd0, Empty}, 32'd1);
        chk("rst_no_frame", {31'd0, txBusy}, 32'd0);

        write_start("a5", 8'hA5);
        collect(FCYC);
        check_frame("a5", 8'hA5, 0);
        chk("a5_busy_cycles", busy_cnt, FCYC);
        check_idle("a5");

        write_start("07", 8'h07);
        collect(FCYC);
        check_frame("07", 8'h07, 0);
        chk("07_busy_cycles", busy_cnt, FCYC);
        check_idle("07");

        write_start("3c", 8'h3C);
        fork
            collect(2 * FCYC);
            begin
                repeat (6) @(negedge clk);
                ParallelIn = 8'hC3;
                nWE        = 1'b0;
                @(negedge clk);
                nWE = 1'b1;
            end
        join
        check_frame("b2b_3c", 8'h3C, 0);
        check_frame("b2b_c3", 8'hC3, FCYC);
        chk("b2b_busy_cycles", busy_cnt, 2 * FCYC);
        check_idle("b2b");

        @(negedge clk);
        ParallelIn = 8'h11;
        nWE        = 1'b0;
        @(negedge clk);
        ParallelIn = 8'h22;
        @(negedge clk);
        nWE = 1'b1;
        chk("full_empty0", {31'd0, Empty}, 32'd0);
        chk("full_dout_n1", {31'd0, dataOut}, 32'd1);
        @(negedge clk);
        chk("full_dout_n2", {31'd0, dataOut}, 32'd0);
        collect(FCYC);
        check_frame("full_11", 8'h11, 0);
        check_idle("full");
        repeat (8) @(negedge clk);
        chk("full_no_22_busy", {31'd0, txBusy}, 32'd0);
        chk("full_no_22_empty", {31'd0, Empty}, 32'd1);

        write_start("ff", 8'hFF);
        repeat (17) @(negedge clk);
        chk("abort_busy_before", {31'd0, txBusy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_dout", {31'd0, dataOut}, 32'd1);
        chk("abort_busy", {31'd0, txBusy}, 32'd0);
        chk("abort_empty", {31'd0, Empty}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        collect(FCYC);
        zeros = 0;
        for (int i = 0; i < FCYC; i++) begin
            if (samp[i] == 1'b0) zeros++;
        end
        chk("abort_quiet_busy", busy_cnt, 0);
        chk("abort_quiet_zeros", zeros, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 SHALL have port ParallelIn, input, [7:0]: byte to transmit.
REQ-005 SHALL have port nWE, input, 1 bit: active-low write strobe, sampled every rising clk edge.
REQ-006 SHALL have port dataOut, output, 1 bit: serial line, idle high.
REQ-007 SHALL have port txBusy, output, 1 bit: high while a frame is on the line.
REQ-008 SHALL have port Empty, output, 1 bit: high when the holding register can accept a byte.

Function
REQ-009 SHALL frame each byte as: start bit (0), 8 data bits LSB first, optional parity bit (REQ-022), stop bit (1); each bit lasts exactly CLK_DIV cycles.
REQ-010 SHALL capture ParallelIn into the holding register on an edge where nWE=0 and Empty=1; Empty SHALL read 0 from the next cycle.
REQ-011 SHALL ignore nWE=0 when Empty=0: no capture, no error flag, holding contents unchanged.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; transitions occur only on the last cycle of a bit period, except IDLE->START.
REQ-013 IDLE->START SHALL occur on the edge after Empty goes 0: holding contents move to the shifter, Empty returns to 1, dataOut=0, txBusy=1 on that same edge.
REQ-014 Write-to-start-bit latency SHALL be 2 cycles: write sampled at edge N, dataOut=0 from edge N+2.
REQ-015 DATA SHALL shift exactly 8 bits using a 3-bit bit counter; DATA->PARITY when compiled in, otherwise DATA->STOP.
REQ-016 At the end of STOP, with Empty=0, the FSM SHALL go directly to START and perform the REQ-013 transfer (no idle gap); otherwise it SHALL go to IDLE with txBusy=0 and dataOut=1.
REQ-017 A write accepted while a frame is on the line SHALL NOT disturb the frame in progress.
REQ-018 The bit-period counter SHALL be ceil(log2(CLK_DIV)) bits wide, reload to 0 at each bit boundary, and never wrap mid-bit.

Reset
REQ-019 On a clk edge with reset=0: state=IDLE, dataOut=1, txBusy=0, Empty=1, holding register, shifter and counters cleared.
REQ-020 Reset asserted mid-frame SHALL abort the frame, discard the holding byte and drive dataOut=1 from the next edge; nWE SHALL be ignored while reset=0.

Configuration
REQ-021 Macro SERIAL_TX_PARITY_EN SHALL select parity generation.
REQ-022 With SERIAL_TX_PARITY_EN defined, PARITY SHALL transmit one even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles; without it, the PARITY state and its logic SHALL be absent and a frame SHALL be 10 bits long.

Structure
REQ-023 Package serial_pkg SHALL hold the FSM state enum, START_BIT/STOP_BIT constants, DATA_BITS=8 and default CLK_DIV.
REQ-024 Sub-module serial_baud_gen SHALL produce the one-cycle end-of-bit tick; it restarts on every START entry.

Verification
REQ-025 CLK_DIV=4, no parity, write 0xA5 -> dataOut 0,1,0,1,0,0,1,0,1,1, each 4 cycles; txBusy high 40 cycles; dataOut=0 at write edge+2.
REQ-026 Write 0x3C, then 0xC3 while txBusy=1 -> second frame's start bit immediately follows the first stop bit; total txBusy high 80 cycles at CLK_DIV=4.
REQ-027 Two writes while Empty=0 (0x11 accepted, 0x22 attempted) -> only 0x11 held; 0x22 never transmitted.
REQ-028 reset=0 during data bit 3 of 0xFF -> dataOut=1, txBusy=0, Empty=1 on next edge; no further bits emitted.
REQ-029 SERIAL_TX_PARITY_EN, write 0xA5 -> parity bit 0; write 0x07 -> parity bit 1; frame 11 bits (44 cycles at CLK_DIV=4).
